// File: rtl/do_xung.sv
// do_xung: pulse-train measurement block.
// Synchronizes an asynchronous pulse input into the clki domain and measures
// its period (rising edge to rising edge) and high time in clki cycles.
// Each completed measurement is published with a one-cycle valid strobe;
// loss of signal is reported with a one-cycle timeout strobe.
//
// Output strobes: valid and timeout are single-cycle, registered,
// push-only strobes with no backpressure. The consumer must capture
// period/high_time in the cycle valid is high. Both outputs then hold
// until the next valid or reset. valid and timeout are mutually exclusive.
module do_xung #(
   parameter int unsigned W       = 31,
   parameter int unsigned TIMEOUT = 100000000
) (
   input  logic         clki,
   input  logic         rst_n,
   input  logic         xung_in,
   output logic [W-1:0] period,
   output logic [W-1:0] high_time,
   output logic         valid,
   output logic         locked,
   output logic         timeout
);

   localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0] CNT_MAX = W'(TIMEOUT);

   // IDLE: waiting for a first rising edge. MEASURE: counting a period.
   // The state register is kept as a named signal so checkers can bind to it.
   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_t;

   state_t         state;
   state_t         state_nx;

   logic           s1;
   logic           s2;
   logic           s3;
   logic           rise;
   logic           fall;

   logic [W-1:0]   cnt;
   logic [W-1:0]   cnt_nx;
   logic [W-1:0]   hi_latch;
   logic [W-1:0]   hi_nx;
   logic [W-1:0]   period_nx;
   logic [W-1:0]   high_nx;
   logic           valid_nx;
   logic           locked_nx;
   logic           timeout_nx;

   // Two-flop synchronizer followed by an edge-detect register.
   always_ff @(posedge clki or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= xung_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;

   // Next-state, counter and output decode. A rise always takes priority
   // over the timeout check, so a period of exactly TIMEOUT is still measured.
   // The counter holds once it reaches TIMEOUT, so it can never wrap.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      hi_nx      = hi_latch;
      period_nx  = period;
      high_nx    = high_time;
      valid_nx   = 1'b0;
      locked_nx  = locked;
      timeout_nx = 1'b0;

      case (state)
         IDLE: begin
            // The first edge only opens a measurement window.
            if (rise) begin
               state_nx = MEASURE;
               cnt_nx   = CNT_ONE;
               hi_nx    = '0;
            end
         end

         MEASURE: begin
            if (rise) begin
               // hi_latch is zero if no fall was seen since the last rise.
               period_nx = cnt;
               high_nx   = hi_latch;
               valid_nx  = 1'b1;
               locked_nx = 1'b1;
               cnt_nx    = CNT_ONE;
               hi_nx     = '0;
            end else if (cnt == CNT_MAX) begin
               timeout_nx = 1'b1;
               locked_nx  = 1'b0;
               state_nx   = IDLE;
            end else begin
               cnt_nx = cnt + CNT_ONE;
               if (fall) begin
                  hi_nx = cnt;
               end
            end
         end

         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State, counter and published results; reset discards any partial count.
   always_ff @(posedge clki or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         hi_latch  <= '0;
         period    <= '0;
         high_time <= '0;
         valid     <= 1'b0;
         locked    <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         hi_latch  <= hi_nx;
         period    <= period_nx;
         high_time <= high_nx;
         valid     <= valid_nx;
         locked    <= locked_nx;
         timeout   <= timeout_nx;
      end
   end

endmodule

// File: tb/tb_do_xung.sv
// tb_do_xung: table-driven bench for do_xung.
// Two instances share clock and reset: dut_a (TIMEOUT=1000) for steady
// measurements and the asynchronous input, dut_b (TIMEOUT=20) for the
// timeout boundaries. Each table row drives one period of the input and
// states, by hand, what must appear during that period.
module tb_do_xung;

   typedef struct {
      bit sel;    // 0: dut_a, 1: dut_b
      int p;      // period driven in this row, clki cycles
      int h;      // high time driven in this row
      bit v;      // valid expected at row cycle 2 (measures previous row)
      int ep;     // expected period when v
      int eh;     // expected high_time when v
      bit lk;     // expected locked at row cycle 2
      int to1;    // row cycle where a timeout strobe is expected, -1 none
      int to2;    // second timeout strobe cycle, -1 none
      bit lkend;  // expected locked at the last row cycle
   } vec_t;

   logic        clki;
   logic        rst_n;
   logic        drv_a;
   logic        drv_b;
   logic        async_sig;
   logic        use_async;
   logic        cur_sel;
   logic        xung_a;
   logic        xung_b;

   logic [30:0] period_a;
   logic [30:0] high_a;
   logic        valid_a;
   logic        locked_a;
   logic        timeout_a;
   logic [30:0] period_b;
   logic [30:0] high_b;
   logic        valid_b;
   logic        locked_b;
   logic        timeout_b;

   logic [30:0] obs_period;
   logic [30:0] obs_high;
   logic        obs_valid;
   logic        obs_locked;
   logic        obs_timeout;

   int          n_vec;
   int          n_bad;
   int          last_p[2];
   int          last_h[2];
   vec_t        tbl[$];

   assign xung_a = use_async ? async_sig : drv_a;
   assign xung_b = drv_b;

   assign obs_period  = cur_sel ? period_b  : period_a;
   assign obs_high    = cur_sel ? high_b    : high_a;
   assign obs_valid   = cur_sel ? valid_b   : valid_a;
   assign obs_locked  = cur_sel ? locked_b  : locked_a;
   assign obs_timeout = cur_sel ? timeout_b : timeout_a;

   do_xung #(.TIMEOUT(1000)) dut_a (
      .clki      (clki),
      .rst_n     (rst_n),
      .xung_in   (xung_a),
      .period    (period_a),
      .high_time (high_a),
      .valid     (valid_a),
      .locked    (locked_a),
      .timeout   (timeout_a)
   );

   do_xung #(.TIMEOUT(20)) dut_b (
      .clki      (clki),
      .rst_n     (rst_n),
      .xung_in   (xung_b),
      .period    (period_b),
      .high_time (high_b),
      .valid     (valid_b),
      .locked    (locked_b),
      .timeout   (timeout_b)
   );

   // Clock: period 100 time units, rising edges at 50 + 100*m.
   initial begin
      clki = 1'b0;
      forever #50 clki = ~clki;
   end

   // Free-running pulse train at 13.4 clki cycles, high 6.7 cycles.
   // Its edges fall at 25 + 670*k, never on a clki edge.
   initial begin
      async_sig = 1'b0;
      #25;
      forever begin
         async_sig = 1'b1;
         #670;
         async_sig = 1'b0;
         #670;
      end
   end

   // Hard stop in case anything above ever stalls.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input bit sel, input int p, input int h, input bit v,
                               input int ep, input int eh, input bit lk,
                               input int to1, input int to2, input bit lkend);
      vec_t r;
      r.sel = sel; r.p = p; r.h = h; r.v = v; r.ep = ep; r.eh = eh;
      r.lk = lk; r.to1 = to1; r.to2 = to2; r.lkend = lkend;
      return r;
   endfunction

   // Drive one period: the input goes high before row cycle 0 and is first
   // sampled at that edge, so the resulting valid is seen after edge 2.
   task automatic drive_row(input int r, input vec_t v);
      cur_sel = v.sel;
      for (int i = 0; i < v.p; i++) begin
         @(negedge clki);
         if (v.sel) drv_b = (i < v.h);
         else       drv_a = (i < v.h);
         @(posedge clki);
         #1;
         chk($sformatf("r%0d_c%0d_timeout", r, i), 32'(obs_timeout),
             32'(i == v.to1 || i == v.to2));
         chk($sformatf("r%0d_c%0d_valid", r, i), 32'(obs_valid), 32'(i == 2 && v.v));
         if (obs_valid && obs_timeout) begin
            chk($sformatf("r%0d_c%0d_valid_and_timeout", r, i), 32'(obs_valid & obs_timeout), 32'd0);
         end
         if (i == 2) begin
            chk($sformatf("r%0d_locked", r), 32'(obs_locked), 32'(v.lk));
            if (v.v) begin
               chk($sformatf("r%0d_period", r), 32'(obs_period), 32'(v.ep));
               chk($sformatf("r%0d_high_time", r), 32'(obs_high), 32'(v.eh));
               last_p[v.sel] = v.ep;
               last_h[v.sel] = v.eh;
            end
         end
         if (i == v.p - 1) begin
            chk($sformatf("r%0d_locked_end", r), 32'(obs_locked), 32'(v.lkend));
            chk($sformatf("r%0d_period_hold", r), 32'(obs_period), 32'(last_p[v.sel]));
            chk($sformatf("r%0d_high_hold", r), 32'(obs_high), 32'(last_h[v.sel]));
         end
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_period_a"},  32'(period_a),  32'd0);
      chk({tag, "_high_a"},    32'(high_a),    32'd0);
      chk({tag, "_valid_a"},   32'(valid_a),   32'd0);
      chk({tag, "_locked_a"},  32'(locked_a),  32'd0);
      chk({tag, "_timeout_a"}, 32'(timeout_a), 32'd0);
      chk({tag, "_period_b"},  32'(period_b),  32'd0);
      chk({tag, "_high_b"},    32'(high_b),    32'd0);
      chk({tag, "_valid_b"},   32'(valid_b),   32'd0);
      chk({tag, "_locked_b"},  32'(locked_b),  32'd0);
      chk({tag, "_timeout_b"}, 32'(timeout_b), 32'd0);
   endtask

   initial begin
      int n_seen;
      int n_async;

      n_vec     = 0;
      n_bad     = 0;
      last_p    = '{0, 0};
      last_h    = '{0, 0};
      rst_n     = 1'b0;
      drv_a     = 1'b0;
      drv_b     = 1'b0;
      use_async = 1'b0;
      cur_sel   = 1'b0;

      // dut_a, TIMEOUT=1000: lock at 10/5, then a series of period changes.
      tbl.push_back(mk(0, 10,  5, 0,  0,  0, 0, -1, -1, 0));
      tbl.push_back(mk(0, 10,  5, 1, 10,  5, 1, -1, -1, 1));
      tbl.push_back(mk(0, 10,  5, 1, 10,  5, 1, -1, -1, 1));
      tbl.push_back(mk(0, 10,  5, 1, 10,  5, 1, -1, -1, 1));
      tbl.push_back(mk(0,  7,  3, 1, 10,  5, 1, -1, -1, 1));
      tbl.push_back(mk(0,  7,  3, 1,  7,  3, 1, -1, -1, 1));
      tbl.push_back(mk(0,  7,  3, 1,  7,  3, 1, -1, -1, 1));
      tbl.push_back(mk(0,  8,  1, 1,  7,  3, 1, -1, -1, 1));
      tbl.push_back(mk(0,  5,  4, 1,  8,  1, 1, -1, -1, 1));
      tbl.push_back(mk(0,  3,  2, 1,  5,  4, 1, -1, -1, 1));
      tbl.push_back(mk(0, 12, 11, 1,  3,  2, 1, -1, -1, 1));
      tbl.push_back(mk(0, 10,  5, 1, 12, 11, 1, -1, -1, 1));
      // dut_b, TIMEOUT=20: lock, stop low (timeout 20 cycles after the
      // rise cycle), restart, period exactly 20, period 21, stuck high.
      tbl.push_back(mk(1, 10,  5, 0,  0,  0, 0, -1, -1, 0));
      tbl.push_back(mk(1, 10,  5, 1, 10,  5, 1, -1, -1, 1));
      tbl.push_back(mk(1, 10,  5, 1, 10,  5, 1, -1, -1, 1));
      tbl.push_back(mk(1, 40,  5, 1, 10,  5, 1, 22, -1, 0));
      tbl.push_back(mk(1, 10,  5, 0,  0,  0, 0, -1, -1, 0));
      tbl.push_back(mk(1, 10,  5, 1, 10,  5, 1, -1, -1, 1));
      tbl.push_back(mk(1, 20, 10, 1, 10,  5, 1, -1, -1, 1));
      tbl.push_back(mk(1, 20, 10, 1, 20, 10, 1, -1, -1, 1));
      tbl.push_back(mk(1, 20, 10, 1, 20, 10, 1, -1, -1, 1));
      tbl.push_back(mk(1, 21, 10, 1, 20, 10, 1, -1, -1, 1));
      tbl.push_back(mk(1, 21, 10, 0,  0,  0, 0,  1, -1, 0));
      tbl.push_back(mk(1,100, 99, 0,  0,  0, 0,  1, 22, 0));
      tbl.push_back(mk(1, 10,  5, 0,  0,  0, 0, -1, -1, 0));
      tbl.push_back(mk(1, 10,  5, 1, 10,  5, 1, -1, -1, 1));

      // Reset block: hold reset a few cycles, check, release between edges.
      repeat (3) @(posedge clki);
      #1;
      chk_all_zero("in_reset");
      @(negedge clki);
      rst_n = 1'b1;
      @(posedge clki);
      #1;
      chk_all_zero("after_reset");

      for (int r = 0; r < tbl.size(); r++) begin
         drive_row(r, tbl[r]);
      end

      // Short reset in the low phase of a period on dut_b: outputs clear at
      // once, the next rise only restarts, the one after locks again.
      cur_sel = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clki);
         drv_b = (i < 5);
         @(posedge clki);
         #1;
         chk($sformatf("rst_seq_c%0d_valid", i), 32'(valid_b), 32'(i == 2));
      end
      #20;
      rst_n = 1'b0;
      #5;
      chk_all_zero("async_reset");
      #10;
      rst_n = 1'b1;
      last_p = '{0, 0};
      last_h = '{0, 0};
      for (int i = 0; i < 3; i++) begin
         @(posedge clki);
         #1;
         chk($sformatf("post_rst_c%0d_valid", i), 32'(valid_b), 32'd0);
      end
      drive_row(100, mk(1, 10, 5, 0,  0, 0, 0, -1, -1, 0));
      drive_row(101, mk(1, 10, 5, 1, 10, 5, 1, -1, -1, 1));

      // Asynchronous input at 13.4 cycles on dut_a. The first valid may span
      // the switch-over and is skipped.
      cur_sel   = 1'b0;
      use_async = 1'b1;
      n_seen    = 0;
      n_async   = 0;
      for (int c = 0; c < 520; c++) begin
         @(posedge clki);
         #1;
         if (timeout_a) begin
            chk($sformatf("async_c%0d_timeout", c), 32'(timeout_a), 32'd0);
         end
         if (valid_a) begin
            n_seen++;
            if (n_seen > 1) begin
               n_async++;
               chk($sformatf("async_v%0d_period_13_14", n_seen),
                   32'(period_a == 31'd13 || period_a == 31'd14), 32'd1);
               chk($sformatf("async_v%0d_high_6_7", n_seen),
                   32'(high_a == 31'd6 || high_a == 31'd7), 32'd1);
            end
         end
      end
      chk("async_valid_count_ge_30", 32'(n_async >= 30), 32'd1);
      chk("async_locked", 32'(locked_a), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
